// File: rtl/nts_cookie_emitter.sv
// nts_cookie_emitter
// Holds one wrapped NTS cookie (key id, nonce, SIV tag, C2S and S2C ciphertext)
// and serialises it on command as a 26-word NTP extension field over a
// valid/ready stream, most significant word first.
module nts_cookie_emitter #(
  parameter logic [15:0] EXT_TAG          = 16'h0204,
  parameter logic [15:0] EXT_LEN          = 16'h0068,
  parameter bit          CLEAR_AFTER_EMIT = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_areset,
  input  logic        i_keyid_we,
  input  logic [31:0] i_keyid,
  input  logic        i_word_we,
  input  logic [1:0]  i_word_sel,
  input  logic [2:0]  i_word_addr,
  input  logic [31:0] i_word_data,
  input  logic        i_op_emit,
  input  logic        i_tx_ready,
  output logic        o_tx_valid,
  output logic [31:0] o_tx_data,
  output logic        o_tx_first,
  output logic        o_tx_last,
  output logic        o_busy,
  output logic        o_complete,
  output logic        o_error
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Index of the final stream word (the last S2C word).
  localparam logic [4:0] LAST_CNT = 5'd25;
  // Load-map bit that tracks the key id; payload words use bits 0..23.
  localparam int unsigned KEYID_BIT = 24;

  // Start of each payload field inside the 24-word payload store / load map.
  function automatic logic [4:0] base_of(input logic [1:0] sel);
    logic [4:0] base_v;
    case (sel)
      2'd0:    base_v = 5'd0;   // nonce,   4 words
      2'd1:    base_v = 5'd4;   // siv_tag, 4 words
      2'd2:    base_v = 5'd8;   // c2s,     8 words
      2'd3:    base_v = 5'd16;  // s2c,     8 words
      default: base_v = 5'd0;
    endcase
    return base_v;
  endfunction

  state_t      state_r;
  state_t      state_next_s;
  logic [4:0]  cnt_r;
  logic [4:0]  cnt_next_s;
  logic [31:0] keyid_r;
  logic [31:0] payload_r [0:23];
  logic [24:0] map_r;
  logic [24:0] map_next_s;

  logic        tx_valid_r;
  logic [31:0] tx_data_r;
  logic        tx_first_r;
  logic        tx_last_r;
  logic        busy_r;
  logic        complete_r;
  logic        error_r;

  logic        tx_valid_next_s;
  logic [31:0] tx_data_next_s;
  logic        tx_first_next_s;
  logic        tx_last_next_s;
  logic        busy_next_s;
  logic        err_s;

  logic        wr_key_s;
  logic        wr_word_s;
  logic [4:0]  wr_idx_s;
  logic        word_ok_s;
  logic        clear_s;

  logic [4:0]  nxt_cnt_s;
  logic [4:0]  pl_idx_s;
  logic [31:0] emit_word_s;

  // Word that will be presented after the current beat (stream position cnt+1).
  always_comb begin
    nxt_cnt_s = cnt_r + 5'd1;
    pl_idx_s  = nxt_cnt_s - 5'd2;
    if (nxt_cnt_s == 5'd0) begin
      emit_word_s = {EXT_TAG, EXT_LEN};
    end else if (nxt_cnt_s == 5'd1) begin
      emit_word_s = keyid_r;
    end else if (nxt_cnt_s <= LAST_CNT) begin
      emit_word_s = payload_r[pl_idx_s];
    end else begin
      emit_word_s = 32'd0;
    end
  end

  // Next-state, write decode, error detection and next stream outputs.
  always_comb begin
    state_next_s    = state_r;
    cnt_next_s      = cnt_r;
    tx_valid_next_s = tx_valid_r;
    tx_data_next_s  = tx_data_r;
    tx_first_next_s = tx_first_r;
    tx_last_next_s  = tx_last_r;
    busy_next_s     = busy_r;
    err_s           = 1'b0;
    wr_key_s        = 1'b0;
    wr_word_s       = 1'b0;
    clear_s         = 1'b0;
    wr_idx_s        = base_of(i_word_sel) + {2'b00, i_word_addr};
    // nonce and tag are only 4 words deep; c2s/s2c accept any 3-bit address
    word_ok_s       = i_word_sel[1] | ~i_word_addr[2];

    case (state_r)
      ST_IDLE: begin
        wr_key_s = i_keyid_we;
        if (i_word_we) begin
          if (word_ok_s) begin
            wr_word_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          wr_word_s = 1'b0;
        end
        // Emit is judged on the registered complete flag; a coinciding
        // write still lands before any payload word is read out.
        if (i_op_emit) begin
          if (complete_r) begin
            state_next_s    = ST_EMIT;
            cnt_next_s      = 5'd0;
            tx_valid_next_s = 1'b1;
            tx_data_next_s  = {EXT_TAG, EXT_LEN};
            tx_first_next_s = 1'b1;
            tx_last_next_s  = 1'b0;
            busy_next_s     = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_EMIT: begin
        // Register contents are frozen while the stream is running.
        if (i_keyid_we | i_word_we | i_op_emit) begin
          err_s = 1'b1;
        end else begin
          err_s = 1'b0;
        end
        if (tx_valid_r & i_tx_ready) begin
          if (cnt_r == LAST_CNT) begin
            state_next_s    = ST_IDLE;
            cnt_next_s      = 5'd0;
            tx_valid_next_s = 1'b0;
            tx_data_next_s  = 32'd0;
            tx_first_next_s = 1'b0;
            tx_last_next_s  = 1'b0;
            busy_next_s     = 1'b0;
            clear_s         = CLEAR_AFTER_EMIT;
          end else begin
            cnt_next_s      = nxt_cnt_s;
            tx_data_next_s  = emit_word_s;
            tx_first_next_s = 1'b0;
            tx_last_next_s  = (nxt_cnt_s == LAST_CNT);
          end
        end else begin
          // stall: hold word and flags
          cnt_next_s = cnt_r;
        end
      end

      default: begin
        state_next_s    = ST_IDLE;
        cnt_next_s      = 5'd0;
        tx_valid_next_s = 1'b0;
        tx_data_next_s  = 32'd0;
        tx_first_next_s = 1'b0;
        tx_last_next_s  = 1'b0;
        busy_next_s     = 1'b0;
      end
    endcase

    map_next_s = map_r;
    if (clear_s) begin
      map_next_s = 25'd0;
    end else begin
      if (wr_key_s) begin
        map_next_s[KEYID_BIT] = 1'b1;
      end else begin
        map_next_s[KEYID_BIT] = map_r[KEYID_BIT];
      end
      if (wr_word_s) begin
        map_next_s[wr_idx_s] = 1'b1;
      end else begin
        map_next_s[wr_idx_s] = map_r[wr_idx_s];
      end
    end
  end

  // State, counter, load map and registered stream/status outputs.
  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 5'd0;
      map_r      <= 25'd0;
      tx_valid_r <= 1'b0;
      tx_data_r  <= 32'd0;
      tx_first_r <= 1'b0;
      tx_last_r  <= 1'b0;
      busy_r     <= 1'b0;
      complete_r <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      map_r      <= map_next_s;
      tx_valid_r <= tx_valid_next_s;
      tx_data_r  <= tx_data_next_s;
      tx_first_r <= tx_first_next_s;
      tx_last_r  <= tx_last_next_s;
      busy_r     <= busy_next_s;
      complete_r <= &map_next_s;
      error_r    <= err_s;
    end
  end

  // Key id and payload storage; zeroised on reset and optionally after emission.
  always_ff @(posedge i_clk) begin
    if (i_areset || clear_s) begin
      keyid_r <= 32'd0;
      for (int i = 0; i < 24; i++) begin
        payload_r[i] <= 32'd0;
      end
    end else begin
      if (wr_key_s) begin
        keyid_r <= i_keyid;
      end
      if (wr_word_s) begin
        payload_r[wr_idx_s] <= i_word_data;
      end
    end
  end

  assign o_tx_valid = tx_valid_r;
  assign o_tx_data  = tx_data_r;
  assign o_tx_first = tx_first_r;
  assign o_tx_last  = tx_last_r;
  assign o_busy     = busy_r;
  assign o_complete = complete_r;
  assign o_error    = error_r;

endmodule

// File: tb/tb_nts_cookie_emitter.sv
// tb_nts_cookie_emitter
// Self-checking bench: a table of IDLE write/emit vectors, directed multi-cycle
// sequences and a randomized phase compared against a cookie-level model
// (key id, 24 payload words, load flags, expected 26-word stream).
module tb_nts_cookie_emitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        areset, keyid_we, word_we, op_emit, tx_ready;
  logic [31:0] keyid, word_data;
  logic [1:0]  word_sel;
  logic [2:0]  word_addr;

  logic        tx_valid, tx_first, tx_last, busy, complete, err;
  logic [31:0] tx_data;
  logic        tx_valid0, tx_first0, tx_last0, busy0, complete0, err0;
  logic [31:0] tx_data0;

  // second instance (no clear after emit) only sees strobes while en0 is set
  logic en0, use0;
  logic kwe0, wwe0, emit0;
  assign kwe0  = en0 & keyid_we;
  assign wwe0  = en0 & word_we;
  assign emit0 = en0 & op_emit;

  logic        obs_valid, obs_first, obs_last, obs_busy, obs_comp, obs_err;
  logic [31:0] obs_data;
  assign obs_valid = use0 ? tx_valid0 : tx_valid;
  assign obs_first = use0 ? tx_first0 : tx_first;
  assign obs_last  = use0 ? tx_last0  : tx_last;
  assign obs_busy  = use0 ? busy0     : busy;
  assign obs_comp  = use0 ? complete0 : complete;
  assign obs_err   = use0 ? err0      : err;
  assign obs_data  = use0 ? tx_data0  : tx_data;

  nts_cookie_emitter dut (
    .i_clk(clk), .i_areset(areset), .i_keyid_we(keyid_we), .i_keyid(keyid),
    .i_word_we(word_we), .i_word_sel(word_sel), .i_word_addr(word_addr),
    .i_word_data(word_data), .i_op_emit(op_emit), .i_tx_ready(tx_ready),
    .o_tx_valid(tx_valid), .o_tx_data(tx_data), .o_tx_first(tx_first),
    .o_tx_last(tx_last), .o_busy(busy), .o_complete(complete), .o_error(err)
  );

  nts_cookie_emitter #(.CLEAR_AFTER_EMIT(1'b0)) dut0 (
    .i_clk(clk), .i_areset(areset), .i_keyid_we(kwe0), .i_keyid(keyid),
    .i_word_we(wwe0), .i_word_sel(word_sel), .i_word_addr(word_addr),
    .i_word_data(word_data), .i_op_emit(emit0), .i_tx_ready(tx_ready),
    .o_tx_valid(tx_valid0), .o_tx_data(tx_data0), .o_tx_first(tx_first0),
    .o_tx_last(tx_last0), .o_busy(busy0), .o_complete(complete0), .o_error(err0)
  );

  int n_checks = 0;
  int n_errors = 0;

  // cookie-level reference model
  logic [31:0] m_key;
  logic [31:0] m_pl [0:23];
  logic [24:0] m_map;
  bit          m_clear;

  logic [31:0] t_key;
  logic [31:0] t_pl [0:23];
  logic [31:0] got [$];
  logic [31:0] first_stream [$];

  typedef struct {
    logic        kwe;
    logic        wwe;
    logic [1:0]  sel;
    logic [2:0]  addr;
    logic [31:0] data;
    logic        emit;
    logic        exp_err;
    logic        exp_comp;
  } vec_t;
  vec_t tbl [0:7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    keyid_we = 1'b0; keyid = 32'd0; word_we = 1'b0; word_sel = 2'd0;
    word_addr = 3'd0; word_data = 32'd0; op_emit = 1'b0;
  endtask

  function automatic logic model_complete();
    return &m_map;
  endfunction

  task automatic model_reset();
    m_key = 32'd0;
    m_map = 25'd0;
    for (int i = 0; i < 24; i++) m_pl[i] = 32'd0;
  endtask

  function automatic int field_base(input logic [1:0] sel);
    return (sel == 2'd0) ? 0 : (sel == 2'd1) ? 4 : (sel == 2'd2) ? 8 : 16;
  endfunction

  function automatic logic [1:0] sel_of(input int i);
    return (i < 4) ? 2'd0 : (i < 8) ? 2'd1 : (i < 16) ? 2'd2 : 2'd3;
  endfunction

  function automatic logic [2:0] addr_of(input int i);
    int a;
    a = i - field_base(sel_of(i));
    return a[2:0];
  endfunction

  function automatic logic [31:0] exp_word(input int i);
    if (i == 0) return 32'h02040068;
    else if (i == 1) return m_key;
    else return m_pl[i-2];
  endfunction

  task automatic do_reset();
    idle_inputs();
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
    model_reset();
  endtask

  // One IDLE cycle of writes/emit; checks error, complete and emit acceptance.
  task automatic cycle_io(input logic kwe, input logic [31:0] k, input logic wwe,
                          input logic [1:0] sel, input logic [2:0] addr,
                          input logic [31:0] d, input logic emit, output bit accepted);
    bit bad_addr, exp_err, comp_before;
    int idx;
    comp_before = model_complete();
    bad_addr    = wwe && (sel < 2'd2) && (addr > 3'd3);
    exp_err     = bad_addr || (emit && !comp_before);
    accepted    = emit && comp_before;
    keyid_we = kwe; keyid = k; word_we = wwe; word_sel = sel; word_addr = addr;
    word_data = d; op_emit = emit;
    tick();
    idle_inputs();
    if (kwe) begin m_key = k; m_map[24] = 1'b1; end
    if (wwe && !bad_addr) begin
      idx = field_base(sel) + int'(addr);
      m_pl[idx] = d;
      m_map[idx] = 1'b1;
    end
    chk("error", {31'd0, obs_err}, {31'd0, exp_err});
    chk("complete", {31'd0, obs_comp}, {31'd0, model_complete()});
    chk("busy_on_emit", {31'd0, obs_busy}, {31'd0, accepted});
    chk("valid_on_emit", {31'd0, obs_valid}, {31'd0, accepted});
    if (accepted) chk("header_word", obs_data, 32'h02040068);
  endtask

  task automatic load_all(input int skip);
    bit acc;
    cycle_io(1'b1, t_key, 1'b0, 2'd0, 3'd0, 32'd0, 1'b0, acc);
    for (int i = 0; i < 24; i++) begin
      if (i != skip) cycle_io(1'b0, 32'd0, 1'b1, sel_of(i), addr_of(i), t_pl[i], 1'b0, acc);
    end
  endtask

  // Drain the stream from position base; checks flags per beat and stall stability.
  task automatic collect(input int base, input bit rnd, output int cycles);
    logic [31:0] hold;
    bit stalled;
    int cyc, idx;
    got.delete();
    cyc = 0;
    while ((base + got.size()) < 26 && cyc < 1000) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("valid_in_emit", {31'd0, obs_valid}, 32'd1);
      stalled = 1'b0;
      hold = obs_data;
      if (obs_valid && tx_ready) begin
        idx = base + got.size();
        chk("first_flag", {31'd0, obs_first}, {31'd0, (idx == 0)});
        chk("last_flag", {31'd0, obs_last}, {31'd0, (idx == 25)});
        got.push_back(obs_data);
      end else begin
        stalled = 1'b1;
      end
      tick();
      cyc++;
      if (stalled) chk("stall_data", obs_data, hold);
    end
    chk("beats_collected", base + got.size(), 26);
    cycles = cyc;
    tx_ready = 1'b1;
  endtask

  task automatic cmp_stream(input int base);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("word%0d", base + i), got[i], exp_word(base + i));
  endtask

  task automatic after_last();
    if (m_clear) model_reset();
    chk("valid_after_last", {31'd0, obs_valid}, 32'd0);
    chk("busy_after_last", {31'd0, obs_busy}, 32'd0);
    chk("data_after_last", obs_data, 32'd0);
    chk("complete_after_last", {31'd0, obs_comp}, {31'd0, model_complete()});
  endtask

  task automatic emit_full(input bit rnd);
    bit acc;
    int cyc;
    cycle_io(1'b0, 32'd0, 1'b0, 2'd0, 3'd0, 32'd0, 1'b1, acc);
    if (acc) begin
      collect(0, rnd, cyc);
      cmp_stream(0);
      after_last();
    end
  endtask

  initial begin
    bit acc;
    int cyc;
    en0 = 1'b0; use0 = 1'b0; m_clear = 1'b1; tx_ready = 1'b1;
    t_key = 32'h6c47f0d3;
    t_pl[0] = 32'hcd65766f; t_pl[1] = 32'h2c8fb4cc;
    t_pl[2] = 32'h6b8d5b7a; t_pl[3] = 32'hca60c5ec;
    for (int i = 4; i < 24; i++) t_pl[i] = 32'ha5000000 | (32'h00010101 * i);

    // reset state
    do_reset();
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_data", tx_data, 32'd0);
    chk("rst_first", {31'd0, tx_first}, 32'd0);
    chk("rst_last", {31'd0, tx_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_complete", {31'd0, complete}, 32'd0);
    chk("rst_error", {31'd0, err}, 32'd0);

    // table of IDLE vectors from an empty map
    tbl[0] = '{1'b0, 1'b0, 2'd0, 3'd0, 32'd0,          1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 2'd0, 3'd5, 32'h11111111,   1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 2'd1, 3'd4, 32'h22222222,   1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 2'd2, 3'd7, 32'h33333333,   1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 2'd0, 3'd0, 32'd0,          1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 2'd3, 3'd7, 32'h44444444,   1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 2'd1, 3'd3, 32'h55555555,   1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 2'd0, 3'd7, 32'h66666666,   1'b1, 1'b1, 1'b0};
    for (int v = 0; v < 8; v++) begin
      keyid_we = tbl[v].kwe; keyid = 32'hdeadbeef; word_we = tbl[v].wwe;
      word_sel = tbl[v].sel; word_addr = tbl[v].addr; word_data = tbl[v].data;
      op_emit = tbl[v].emit;
      tick();
      idle_inputs();
      chk($sformatf("tbl%0d_error", v), {31'd0, err}, {31'd0, tbl[v].exp_err});
      chk($sformatf("tbl%0d_complete", v), {31'd0, complete}, {31'd0, tbl[v].exp_comp});
      chk($sformatf("tbl%0d_valid", v), {31'd0, tx_valid}, 32'd0);
    end

    // 1: back-to-back emission
    do_reset();
    load_all(-1);
    cycle_io(1'b0, 32'd0, 1'b0, 2'd0, 3'd0, 32'd0, 1'b1, acc);
    collect(0, 1'b0, cyc);
    chk("t1_cycles", cyc, 26);
    chk("t1_w0", got[0], 32'h02040068);
    chk("t1_w1", got[1], 32'h6c47f0d3);
    chk("t1_w2", got[2], 32'hcd65766f);
    chk("t1_w5", got[5], 32'hca60c5ec);
    cmp_stream(0);
    after_last();

    // 2: random ready
    load_all(-1);
    emit_full(1'b1);

    // 3: incomplete cookie rejected
    load_all(23);
    cycle_io(1'b0, 32'd0, 1'b0, 2'd0, 3'd0, 32'd0, 1'b1, acc);
    tick();
    chk("t3_error_clears", {31'd0, err}, 32'd0);
    chk("t3_valid", {31'd0, tx_valid}, 32'd0);

    // 4: write during a stall is rejected and leaves c2s word 0 unchanged
    cycle_io(1'b0, 32'd0, 1'b1, 2'd3, 3'd7, t_pl[23], 1'b0, acc);
    cycle_io(1'b0, 32'd0, 1'b0, 2'd0, 3'd0, 32'd0, 1'b1, acc);
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t4_at_word5", tx_data, 32'hca60c5ec);
    tx_ready = 1'b0;
    word_we = 1'b1; word_sel = 2'd2; word_addr = 3'd0; word_data = 32'hffffffff;
    tick();
    idle_inputs();
    chk("t4_error", {31'd0, err}, 32'd1);
    chk("t4_hold", tx_data, 32'hca60c5ec);
    tick();
    chk("t4_error_1cyc", {31'd0, err}, 32'd0);
    collect(5, 1'b0, cyc);
    chk("t4_word10", got[5], t_pl[8]);
    cmp_stream(5);
    after_last();

    // 5a: cleared cookie cannot be re-emitted
    cycle_io(1'b0, 32'd0, 1'b0, 2'd0, 3'd0, 32'd0, 1'b1, acc);
    chk("t5_reemit_rejected", {31'd0, acc}, 32'd0);

    // 5b: without clearing, re-emission repeats the stream
    en0 = 1'b1; use0 = 1'b1; m_clear = 1'b0;
    do_reset();
    load_all(-1);
    emit_full(1'b0);
    first_stream = got;
    emit_full(1'b1);
    chk("t5_len", got.size(), first_stream.size());
    for (int i = 0; i < 26 && i < got.size() && i < first_stream.size(); i++)
      chk($sformatf("t5_repeat%0d", i), got[i], first_stream[i]);
    en0 = 1'b0; use0 = 1'b0; m_clear = 1'b1;

    // 6: reset in the middle of the stream
    do_reset();
    load_all(-1);
    cycle_io(1'b0, 32'd0, 1'b0, 2'd0, 3'd0, 32'd0, 1'b1, acc);
    tx_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("t6_at_word12", tx_data, t_pl[10]);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    model_reset();
    chk("t6_valid", {31'd0, tx_valid}, 32'd0);
    chk("t6_data", tx_data, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_complete", {31'd0, complete}, 32'd0);
    chk("t6_first_last", {30'd0, tx_first, tx_last}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_beats", {31'd0, tx_valid}, 32'd0);
    end
    load_all(-1);
    emit_full(1'b1);

    // randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      cycle_io(1'($urandom_range(0, 7) == 0), $urandom, 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 11) == 0), acc);
      if (acc) begin
        collect(0, 1'b1, cyc);
        cmp_stream(0);
        after_last();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
